// File: rtl/dino_sprite_render.sv
// Dino sprite renderer: frame-latched animation select plus a 2-stage hit-test
// and bitmap lookup that turns the VGA scan position into a per-pixel "on" flag.
module dino_sprite_render #(
  parameter int SCALE_LOG2 = 1,
  parameter int H_BITS     = 10,
  parameter int V_BITS     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sprite,
  input  logic              freeze,
  input  logic              pix_en,
  input  logic              video_on,
  input  logic [H_BITS-1:0] hcount,
  input  logic [V_BITS-1:0] vcount,
  input  logic [H_BITS-1:0] dino_x,
  input  logic [V_BITS-1:0] dino_y,
  output logic              pix_valid,
  output logic              pix_on,
  output logic              frame_sel
);

  localparam int SIZE = 16 << SCALE_LOG2;
  localparam logic [H_BITS:0] SIZE_H = SIZE[H_BITS:0];
  localparam logic [V_BITS:0] SIZE_V = SIZE[V_BITS:0];

  // Row bitmap indexed by {frame, row}; bit n is column n (col 0 = left).
  function automatic logic [15:0] sprite_row(input int idx);
    int row;
    row = idx % 16;
    if (row < 4)        return 16'hFF00;
    else if (row < 12)  return 16'h3FFC;
    else if (idx >= 16) return 16'h0C00;
    else                return 16'h0030;
  endfunction

  logic [15:0] rom [32];

  for (genvar gi = 0; gi < 32; gi++) begin : g_rom
    assign rom[gi] = sprite_row(gi);
  end

  logic            frame_sel_q, frame_sel_d;
  logic            v1_q, v1_d;
  logic            in_box1_q, in_box1_d;
  logic [3:0]      row1_q, row1_d;
  logic [3:0]      col1_q, col1_d;
  logic            f1_q, f1_d;
  logic            pix_valid_q, pix_valid_d;
  logic            pix_on_q, pix_on_d;
  logic [H_BITS:0] h_end;
  logic [V_BITS:0] v_end;

  always_comb begin
    frame_sel_d = frame_sel_q;
    if (pix_en && (hcount == '0) && (vcount == '0) && !freeze) begin
      frame_sel_d = sprite;
    end

    // One extra bit so a sprite hanging off the right/bottom edge clips instead of wrapping.
    h_end     = {1'b0, dino_x} + SIZE_H;
    v_end     = {1'b0, dino_y} + SIZE_V;
    in_box1_d = video_on
                && (hcount >= dino_x) && ({1'b0, hcount} < h_end)
                && (vcount >= dino_y) && ({1'b0, vcount} < v_end);
    col1_d    = 4'((hcount - dino_x) >> SCALE_LOG2);
    row1_d    = 4'((vcount - dino_y) >> SCALE_LOG2);
    v1_d      = pix_en;
    f1_d      = frame_sel_q;

    pix_valid_d = v1_q;
    pix_on_d    = in_box1_q & rom[{f1_q, row1_q}][col1_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_sel_q <= 1'b0;
      v1_q        <= 1'b0;
      in_box1_q   <= 1'b0;
      row1_q      <= '0;
      col1_q      <= '0;
      f1_q        <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_on_q    <= 1'b0;
    end else begin
      frame_sel_q <= frame_sel_d;
      v1_q        <= v1_d;
      in_box1_q   <= in_box1_d;
      row1_q      <= row1_d;
      col1_q      <= col1_d;
      f1_q        <= f1_d;
      pix_valid_q <= pix_valid_d;
      pix_on_q    <= pix_on_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_on    = pix_on_q;
  assign frame_sel = frame_sel_q;

endmodule

// File: tb/tb_dino_sprite_render.sv
// Scoreboard bench for dino_sprite_render: one instance at 1x scale, one at 2x,
// driven with the same directed scan vectors.
module tb_dino_sprite_render;

  logic       clk = 1'b0;
  logic       rst, sprite, freeze, pix_en, video_on;
  logic [9:0] hcount, vcount, dino_x, dino_y;
  logic       pv0, po0, fs0, pv1, po1, fs1;

  always #5 clk = ~clk;

  dino_sprite_render #(.SCALE_LOG2(0), .H_BITS(10), .V_BITS(10)) dut0 (
    .clk(clk), .rst(rst), .sprite(sprite), .freeze(freeze), .pix_en(pix_en),
    .video_on(video_on), .hcount(hcount), .vcount(vcount), .dino_x(dino_x),
    .dino_y(dino_y), .pix_valid(pv0), .pix_on(po0), .frame_sel(fs0)
  );

  dino_sprite_render #(.SCALE_LOG2(1), .H_BITS(10), .V_BITS(10)) dut1 (
    .clk(clk), .rst(rst), .sprite(sprite), .freeze(freeze), .pix_en(pix_en),
    .video_on(video_on), .hcount(hcount), .vcount(vcount), .dino_x(dino_x),
    .dino_y(dino_y), .pix_valid(pv1), .pix_on(po1), .frame_sel(fs1)
  );

  typedef struct {
    bit exp;
    int h;
    int v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_frame = 1'b0;
  bit   last_en = 1'b0;

  // Hand-written sprite table: head, body, and the two leg poses.
  function automatic bit bmp(bit f, int row, int col);
    if (row < 4)  return col >= 8;
    if (row < 12) return (col >= 2) && (col <= 13);
    if (f)        return (col == 10) || (col == 11);
    return (col == 4) || (col == 5);
  endfunction

  function automatic bit model_on(int scale, bit f, int h, int v, int dx, int dy, bit von);
    int size;
    size = 16 << scale;
    if (!von || h < dx || h >= dx + size || v < dy || v >= dy + size) return 1'b0;
    return bmp(f, (v - dy) >> scale, (h - dx) >> scale);
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic px(int h, int v, bit en = 1'b1, bit von = 1'b1);
    exp_t e;
    hcount   = 10'(h);
    vcount   = 10'(v);
    pix_en   = en;
    video_on = von;
    if (en) begin
      e.h = h; e.v = v;
      e.exp = model_on(0, exp_frame, h, v, int'(dino_x), int'(dino_y), von);
      q0.push_back(e);
      e.exp = model_on(1, exp_frame, h, v, int'(dino_x), int'(dino_y), von);
      q1.push_back(e);
      if (h == 0 && v == 0 && !freeze) exp_frame = sprite;
    end
    last_en = en;
    @(posedge clk); #1;
    check("frame_sel0", fs0, exp_frame);
    check("frame_sel1", fs1, exp_frame);
  endtask

  task automatic scan(int v, int h0, int h1);
    for (int h = h0; h <= h1; h++) px(h % 1024, v);
  endtask

  // A pixel sampled one edge before reset is still in flight and gets dropped.
  task automatic rst_cycle(bit en);
    rst    = 1'b1;
    pix_en = en;
    hcount = '0;
    vcount = '0;
    if (last_en) begin
      void'(q0.pop_back());
      void'(q1.pop_back());
    end
    last_en   = 1'b0;
    exp_frame = 1'b0;
    @(posedge clk); #1;
    check("rst_valid0", pv0, 1'b0);
    check("rst_on0", po0, 1'b0);
    check("rst_frame0", fs0, 1'b0);
    check("rst_valid1", pv1, 1'b0);
    check("rst_on1", po1, 1'b0);
    check("rst_frame1", fs1, 1'b0);
    rst = 1'b0;
  endtask

  task automatic idle_check();
    pix_en  = 1'b0;
    last_en = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid0", pv0, 1'b0);
    check("post_rst_on0", po0, 1'b0);
    check("post_rst_valid1", pv1, 1'b0);
    check("post_rst_on1", po1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (pv0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_valid: got pix_valid=1 want no output");
      end else begin
        exp_t e;
        e = q0.pop_front();
        $display("dut0 h=%0d v=%0d pix_on=%b exp=%b", e.h, e.v, po0, e.exp);
        if (po0 !== e.exp) begin
          errors++;
          $display("FAIL dut0_pix_on h=%0d v=%0d: got %b want %b", e.h, e.v, po0, e.exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (pv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_valid: got pix_valid=1 want no output");
      end else begin
        exp_t e;
        e = q1.pop_front();
        $display("dut1 h=%0d v=%0d pix_on=%b exp=%b", e.h, e.v, po1, e.exp);
        if (po1 !== e.exp) begin
          errors++;
          $display("FAIL dut1_pix_on h=%0d v=%0d: got %b want %b", e.h, e.v, po1, e.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sprite = 1'b1; freeze = 1'b0; pix_en = 1'b0; video_on = 1'b1;
    hcount = '0; vcount = '0; dino_x = 10'd100; dino_y = 10'd200;

    // Reset with pix_en toggling at the frame-start position: nothing latches.
    rst_cycle(1'b1);
    rst_cycle(1'b0);
    rst_cycle(1'b1);
    idle_check();
    idle_check();

    // Shape at 1x: head on row 200, legs on row 212, nothing on row 216.
    sprite = 1'b0;
    px(0, 0);
    scan(200, 95, 109);
    px(110, 200, 1'b1, 1'b0);
    scan(200, 111, 120);
    scan(212, 98, 120);
    scan(216, 98, 120);
    px(112, 200, 1'b0);

    // Mid-frame sprite toggle waits for the next frame start.
    sprite = 1'b1;
    px(300, 50);
    scan(212, 100, 115);
    px(0, 0);
    scan(212, 100, 115);

    // Freeze across a frame start keeps frame 1; releasing it picks up frame 0.
    sprite = 1'b0;
    freeze = 1'b1;
    px(0, 0);
    freeze = 1'b0;
    scan(212, 100, 115);
    px(0, 0);
    scan(212, 100, 115);

    // Right-edge clipping: columns past 1023 must not wrap to hcount 0..16.
    dino_x = 10'd1015;
    dino_y = 10'd0;
    scan(0, 1010, 1040);
    scan(8, 1010, 1040);

    // Reset pulsed in the middle of a lit run.
    dino_x = 10'd100;
    dino_y = 10'd200;
    sprite = 1'b1;
    px(0, 0);
    scan(200, 106, 110);
    px(111, 200);
    rst_cycle(1'b1);
    idle_check();
    idle_check();
    scan(200, 106, 116);

    for (int i = 0; i < 4; i++) px(5, 5, 1'b0);

    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0_drain: got %0d pending want 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1_drain: got %0d pending want 0", q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
